// File: rtl/lsh_pkg.sv
// lsh_pkg: shared base encoding, window id type and sequencer state enum.
package lsh_pkg;
    typedef logic [1:0] base_t;
    localparam base_t BASE_A = 2'b00;
    localparam base_t BASE_C = 2'b01;
    localparam base_t BASE_G = 2'b10;
    localparam base_t BASE_T = 2'b11;
    typedef logic [31:0] window_id_t;
    localparam logic signed [31:0] NO_MATCH = -32'sd1;
    typedef enum logic [2:0] {IDLE, START_RST, FILL, HASH, COMMIT, HRST, CALC, DONE} seq_state_e;
endpackage

// File: rtl/window_shift_reg.sv
// window_shift_reg: window array; each shift moves BASES_PER_BEAT new bases in at the youngest end.
module window_shift_reg import lsh_pkg::*; #(
    parameter int WINDOW_SIZE    = 128,
    parameter int BASES_PER_BEAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift,
    input  logic [2*BASES_PER_BEAT-1:0] bases,
    output base_t                       window [WINDOW_SIZE]
);
    always_ff @(posedge clk) begin
        if (rst) window <= '{default: '0};
        else if (shift) begin
            for (int i = 0; i < WINDOW_SIZE - BASES_PER_BEAT; i++) window[i] <= window[i + BASES_PER_BEAT];
            for (int i = 0; i < BASES_PER_BEAT; i++) window[WINDOW_SIZE - BASES_PER_BEAT + i] <= bases[2*i +: 2];
        end
    end
endmodule

// File: rtl/window_sequencer.sv
// window_sequencer: slices a base stream into overlapping windows and sequences hasher/hash_table/stats.
// Optional WINDOW_SEQUENCER_OVERFLOW_CHECK_EN: reference windows past MAX_WINDOWS skip insert and set overflow.
module window_sequencer import lsh_pkg::*; #(
    parameter int WINDOW_SIZE    = 128,
    parameter int KMER_SIZE      = 16,
    parameter int BASES_PER_BEAT = 1,
    parameter int MAX_WINDOWS    = 512,
    parameter int OP_CYCLES      = 2,
    parameter int RST_CYCLES     = 2
) (
    input  logic                        clk,
    input  logic                        reset_window_sequencer,
    input  logic                        seq_start,
    input  logic                        seq_is_reference,
    output logic                        seq_busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*BASES_PER_BEAT-1:0] in_bases,
    input  logic                        in_last,
    output base_t                       window [WINDOW_SIZE],
    output window_id_t                  window_id,
    output logic                        ready_for_hashing,
    input  logic                        hashing_is_done,
    output logic                        reset_window_hasher,
    output logic                        reset_stats,
    output logic                        is_insert,
    output logic                        is_query,
    output logic                        calculate_matched_window,
    input  logic signed [31:0]          matched_window_id,
    output logic                        result_valid,
`ifdef WINDOW_SEQUENCER_OVERFLOW_CHECK_EN
    output logic                        overflow,
`endif
    output logic signed [31:0]          result_window_id
);
    localparam int FW     = $clog2(WINDOW_SIZE + 1);
    localparam int STRIDE = WINDOW_SIZE - KMER_SIZE + 1;

    if (STRIDE % BASES_PER_BEAT != 0 || MAX_WINDOWS < 1) begin : g_bad_cfg
        $error("window stride must be a multiple of BASES_PER_BEAT");
    end

    seq_state_e    state, state_n, end_state;
    logic [7:0]    cnt;
    logic [FW-1:0] fill;
    logic          is_ref, last_pend, accept, full, skip;

    window_shift_reg #(.WINDOW_SIZE(WINDOW_SIZE), .BASES_PER_BEAT(BASES_PER_BEAT)) u_shift (
        .clk(clk), .rst(reset_window_sequencer), .shift(accept), .bases(in_bases), .window(window)
    );

`ifdef WINDOW_SEQUENCER_OVERFLOW_CHECK_EN
    assign skip = is_ref && window_id >= window_id_t'(MAX_WINDOWS);
`else
    assign skip = 1'b0;
`endif

    assign seq_busy                 = state != IDLE;
    assign in_ready                 = state == FILL;
    assign ready_for_hashing        = state == HASH;
    assign reset_window_hasher      = state == START_RST || state == HRST;
    assign reset_stats              = state == START_RST;
    assign is_insert                = state == COMMIT && is_ref;
    assign is_query                 = state == COMMIT && !is_ref;
    assign calculate_matched_window = state == CALC;
    assign result_valid             = state == DONE;

    always_comb begin
        accept    = state == FILL && in_valid;
        full      = fill + FW'(BASES_PER_BEAT) == FW'(WINDOW_SIZE);
        end_state = is_ref ? IDLE : CALC;
        state_n   = state;
        unique case (state)
            IDLE:      state_n = seq_start ? START_RST : IDLE;
            START_RST: state_n = cnt == 8'(RST_CYCLES - 1) ? FILL : START_RST;
            FILL:      state_n = !accept ? FILL : full ? HASH : in_last ? end_state : FILL;
            // a window completed by the final beat goes straight to end handling, skipping HRST
            HASH:      state_n = !hashing_is_done ? HASH : !skip ? COMMIT : last_pend ? end_state : HRST;
            COMMIT:    state_n = cnt != 8'(OP_CYCLES - 1) ? COMMIT : last_pend ? end_state : HRST;
            HRST:      state_n = cnt == 8'(RST_CYCLES - 1) ? FILL : HRST;
            CALC:      state_n = cnt == 8'(OP_CYCLES - 1) ? DONE : CALC;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_window_sequencer) begin
            state            <= IDLE;
            cnt              <= '0;
            fill             <= '0;
            is_ref           <= 1'b0;
            last_pend        <= 1'b0;
            window_id        <= '0;
            result_window_id <= NO_MATCH;
`ifdef WINDOW_SEQUENCER_OVERFLOW_CHECK_EN
            overflow         <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 8'd1;
            if (state == IDLE && seq_start) begin
                is_ref    <= seq_is_reference;
                window_id <= '0;
                fill      <= '0;
                last_pend <= 1'b0;
`ifdef WINDOW_SEQUENCER_OVERFLOW_CHECK_EN
                overflow  <= 1'b0;
`endif
            end
            if (accept) begin
                fill      <= fill + FW'(BASES_PER_BEAT);
                last_pend <= last_pend | in_last;
            end
            // the shift register already holds the overlap; only the count rewinds
            if (state == HRST && state_n == FILL) begin
                fill      <= FW'(KMER_SIZE - 1);
                window_id <= window_id + 32'd1;
            end
            if (state == CALC && state_n == DONE) result_window_id <= matched_window_id;
`ifdef WINDOW_SEQUENCER_OVERFLOW_CHECK_EN
            if (state == HASH && hashing_is_done && skip) overflow <= 1'b1;
`endif
        end
    end
endmodule
